// File: rtl/clk_wiz.sv
// Pixel clock generator: integer divide of clk_50m with a sticky lock flag
// raised after a fixed count of complete clk_pix periods.
module clk_wiz #(
  parameter int DIV          = 2,
  parameter int LOCK_PERIODS = 64
) (
  output logic clk_pix,
  input  logic rst_n,
  output logic clk_pix_locked,
  input  logic clk_50m
);

  localparam int HIGH = DIV - DIV / 2;
  localparam int DW   = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int LW   = (LOCK_PERIODS > 1) ?
                        $clog2(LOCK_PERIODS + 1) : 1;

  localparam logic [DW-1:0] DIV_MAX = DW'(DIV - 1);
  localparam logic [DW-1:0] HI_CNT  = DW'(HIGH);
  localparam logic [LW-1:0] LP_CNT  = LW'(LOCK_PERIODS);
  localparam logic [LW-1:0] LP_LAST = LW'(LOCK_PERIODS - 1);

  if (DIV < 2 || LOCK_PERIODS < 1) begin : g_param_err
    $error("clk_wiz: need DIV >= 2 and LOCK_PERIODS >= 1");
  end

  // Initialisers match reset values so an unreset sim shows 0, not X.
  logic [DW-1:0] div_cnt  = '0;
  logic [LW-1:0] lock_cnt = '0;
  logic          pix_q    = 1'b0;
  logic          lock_q   = 1'b0;
  logic          wrap;

  assign wrap = (div_cnt == DIV_MAX);

  always_ff @(posedge clk_50m) begin
    if (!rst_n) begin
      div_cnt  <= '0;
      lock_cnt <= '0;
      pix_q    <= 1'b0;
      lock_q   <= 1'b0;
    end else begin
      div_cnt <= wrap ? '0 : div_cnt + 1'b1;
      pix_q   <= (div_cnt < HI_CNT);
      // One lock step per completed clk_pix period; saturates.
      if (wrap) begin
        if (lock_cnt < LP_CNT)
          lock_cnt <= lock_cnt + 1'b1;
        if (lock_cnt == LP_LAST)
          lock_q <= 1'b1;
      end
    end
  end

  assign clk_pix        = pix_q;
  assign clk_pix_locked = lock_q;

endmodule

// File: tb/tb_clk_wiz.sv
// Self-checking bench for clk_wiz: four parameterisations driven from one
// clock, checked against vector tables, hand sequences and an edge model.
module tb_clk_wiz;

  logic       clk_50m = 1'b0;
  logic [3:0] rst_n   = 4'b0000;
  logic [3:0] pix;
  logic [3:0] lock;

  int n [4];
  int checks   = 0;
  int failures = 0;

  always #10 clk_50m = ~clk_50m;

  clk_wiz #(.DIV(2), .LOCK_PERIODS(4)) u_d2 (
    .clk_pix(pix[0]), .rst_n(rst_n[0]),
    .clk_pix_locked(lock[0]), .clk_50m(clk_50m));
  clk_wiz #(.DIV(4), .LOCK_PERIODS(2)) u_d4 (
    .clk_pix(pix[1]), .rst_n(rst_n[1]),
    .clk_pix_locked(lock[1]), .clk_50m(clk_50m));
  clk_wiz #(.DIV(5), .LOCK_PERIODS(1)) u_d5 (
    .clk_pix(pix[2]), .rst_n(rst_n[2]),
    .clk_pix_locked(lock[2]), .clk_50m(clk_50m));
  clk_wiz #(.DIV(2), .LOCK_PERIODS(64)) u_l64 (
    .clk_pix(pix[3]), .rst_n(rst_n[3]),
    .clk_pix_locked(lock[3]), .clk_50m(clk_50m));

  function automatic int div_of(int i);
    case (i)
      0: return 2;
      1: return 4;
      2: return 5;
      default: return 2;
    endcase
  endfunction

  function automatic int lp_of(int i);
    case (i)
      0: return 4;
      1: return 2;
      2: return 1;
      default: return 64;
    endcase
  endfunction

  // n = rising edges with rst_n high since the last reset edge.
  function automatic logic exp_pix(int i);
    int d = div_of(i);
    if (n[i] == 0) return 1'b0;
    return ((n[i] - 1) % d) < (d - d / 2);
  endfunction

  function automatic logic exp_lock(int i);
    return n[i] >= lp_of(i) * div_of(i);
  endfunction

  task automatic tick();
    @(posedge clk_50m);
    #1;
    for (int i = 0; i < 4; i++)
      n[i] = rst_n[i] ? n[i] + 1 : 0;
  endtask

  task automatic chk(string name, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%b exp=%b t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_model(int i, string tag);
    chk($sformatf("%s_pix[%0d] n=%0d", tag, i, n[i]), pix[i], exp_pix(i));
    chk($sformatf("%s_lock[%0d] n=%0d", tag, i, n[i]), lock[i], exp_lock(i));
  endtask

  typedef struct {
    logic rst;
    logic pix;
    logic lock;
  } vec_t;

  vec_t tbl [16];

  logic [0:19] pat4;
  logic [0:19] pat5;
  int   rises;
  logic prev;
  logic xseen;

  initial begin
    for (int i = 0; i < 4; i++) n[i] = 0;

    // DIV=2, LP=4: 3 reset edges, then toggle; lock on edge 8.
    tbl = '{
      '{1'b0, 1'b0, 1'b0}, '{1'b0, 1'b0, 1'b0},
      '{1'b0, 1'b0, 1'b0}, '{1'b1, 1'b1, 1'b0},
      '{1'b1, 1'b0, 1'b0}, '{1'b1, 1'b1, 1'b0},
      '{1'b1, 1'b0, 1'b0}, '{1'b1, 1'b1, 1'b0},
      '{1'b1, 1'b0, 1'b0}, '{1'b1, 1'b1, 1'b0},
      '{1'b1, 1'b0, 1'b1}, '{1'b1, 1'b1, 1'b1},
      '{1'b1, 1'b0, 1'b1}, '{1'b1, 1'b1, 1'b1},
      '{1'b1, 1'b0, 1'b1}, '{1'b1, 1'b1, 1'b1}
    };
    pat4 = 20'b11001100110011001100;
    pat5 = 20'b11100111001110011100;

    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("powerup_pix[%0d]", i), pix[i], 1'b0);
      chk($sformatf("powerup_lock[%0d]", i), lock[i], 1'b0);
    end

    for (int k = 0; k < 16; k++) begin
      rst_n[0] = tbl[k].rst;
      tick();
      chk($sformatf("tbl_pix[%0d]", k), pix[0], tbl[k].pix);
      chk($sformatf("tbl_lock[%0d]", k), lock[0], tbl[k].lock);
    end
    for (int k = 0; k < 100; k++) begin
      tick();
      chk($sformatf("hold_lock[%0d]", k), lock[0], 1'b1);
    end

    // DIV=4/LP=2 and DIV=5/LP=1 released together.
    rst_n[1] = 1'b1;
    rst_n[2] = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      tick();
      chk($sformatf("d4_pix e%0d", e), pix[1], pat4[e-1]);
      chk($sformatf("d5_pix e%0d", e), pix[2], pat5[e-1]);
      chk($sformatf("d4_lock e%0d", e), lock[1], e >= 8);
      chk($sformatf("d5_lock e%0d", e), lock[2], e >= 5);
    end

    // One-cycle reset pulse while locked.
    rst_n[0] = 1'b0;
    tick();
    chk("pulse_pix", pix[0], 1'b0);
    chk("pulse_lock", lock[0], 1'b0);
    rst_n[0] = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      chk($sformatf("relock_pix e%0d", e), pix[0], e % 2 == 1);
      chk($sformatf("relock_lock e%0d", e), lock[0], e == 8);
    end

    // Reset in the middle of acquisition: no carry-over.
    rst_n[0] = 1'b0;
    tick();
    rst_n[0] = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      tick();
      chk($sformatf("acq_lock e%0d", e), lock[0], 1'b0);
    end
    rst_n[0] = 1'b0;
    for (int e = 5; e <= 6; e++) begin
      tick();
      chk($sformatf("acq_rst_lock e%0d", e), lock[0], 1'b0);
    end
    rst_n[0] = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      chk($sformatf("acq2_lock e%0d", e), lock[0], e == 8);
    end

    // Long run on LP=64: count clk_pix rising edges, watch for X.
    rst_n[3] = 1'b0;
    tick();
    rst_n[3] = 1'b1;
    rises = 0;
    prev  = pix[3];
    xseen = 1'b0;
    for (int e = 1; e <= 10000; e++) begin
      tick();
      if ($isunknown({pix[3], lock[3]})) xseen = 1'b1;
      if (pix[3] && !prev) rises++;
      prev = pix[3];
    end
    checks++;
    if (rises != 5000) begin
      failures++;
      $display("FAIL long_freq got=%0d exp=5000", rises);
    end
    chk("long_no_x", xseen, 1'b0);
    chk("long_lock", lock[3], 1'b1);

    // Random reset activity on all four against the edge model.
    for (int e = 0; e < 3000; e++) begin
      for (int i = 0; i < 4; i++) begin
        if (i == 3)
          rst_n[i] = ($urandom_range(0, 399) != 0);
        else
          rst_n[i] = ($urandom_range(0, 59) != 0);
      end
      tick();
      for (int i = 0; i < 4; i++) chk_model(i, "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
